// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port, fixed-latency SRAM between the
// instruction-fetch path (IF) and the data-memory path (MEM). Each access is
// a multi-cycle transaction: address/data/controls are registered on the grant
// edge, held for WAIT_CYCLES cycles, then the owner gets a one-cycle ready
// pulse in the RESP state. MEM has fixed priority over IF.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   if_req/if_addr             IF read request (held until if_ready) + address
//   if_rdata/if_ready          IF read data and one-cycle completion pulse
//   mem_r_en/mem_w_en          MEM read/write request (held until mem_ready)
//   mem_addr/mem_wdata         MEM address and write data
//   mem_rdata/mem_ready        MEM read data and one-cycle completion pulse
//   freeze                     pipeline freeze while a MEM access is pending
//   sram_addr/sram_wdata       registered SRAM address and write data
//   sram_we/sram_oe            registered SRAM write / output enables
//   sram_rdata                 SRAM read data
//
// Handshake: a requester raises its request and holds it (with stable
// address/data) until it sees its ready pulse; ready is high for exactly one
// cycle and the data output is valid in that cycle. The arbiter only samples
// requests in IDLE. The FSM state is the named signal 'state' and the access
// counter is 'cnt', both visible for checkers.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_ACC = 2'd1,
    IF_ACC  = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

  // Counter value on the last cycle the SRAM controls are held.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       owner;
  logic       mem_req;

  assign mem_req = mem_r_en | mem_w_en;

  // Drops in the RESP cycle so the MEM stage advances together with its data.
  assign freeze = mem_req & ~mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner      <= OWNER_IF;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      sram_oe    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
    end else begin
      // Ready pulses are only ever set on the edge entering RESP.
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            // Both enables high counts as a write: oe stays low.
            state      <= MEM_ACC;
            owner      <= OWNER_MEM;
            cnt        <= 4'd0;
            sram_addr  <= mem_addr;
            sram_wdata <= mem_wdata;
            sram_we    <= mem_w_en;
            sram_oe    <= ~mem_w_en;
          end else if (if_req) begin
            state      <= IF_ACC;
            owner      <= OWNER_IF;
            cnt        <= 4'd0;
            sram_addr  <= if_addr;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
            sram_oe    <= 1'b1;
          end
        end
        MEM_ACC, IF_ACC: begin
          if (cnt == LAST_CNT) begin
            if (owner == OWNER_IF) begin
              if_rdata <= sram_rdata;
            end else if (!sram_we) begin
              // sram_we still reflects the access type on this final edge.
              mem_rdata <= sram_rdata;
            end
            sram_we   <= 1'b0;
            sram_oe   <= 1'b0;
            sram_addr <= '0;
            if_ready  <= (owner == OWNER_IF);
            mem_ready <= (owner == OWNER_MEM);
            state     <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with WAIT_CYCLES=4.
// Cycle numbering: cycle 0 is the IDLE cycle in which a request is first
// presented; inputs are driven 1 time unit after a rising edge and outputs are
// sampled 1 unit later, well away from the next edge. A small word-addressed
// SRAM model answers reads combinationally and stores writes on the edge.
module tb_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          mem_r_en;
  logic          mem_w_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          freeze;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_we;
  logic          sram_oe;
  logic [DW-1:0] sram_rdata;

  int passed = 0;
  int total  = 0;

  sram_arbiter #(.WAIT_CYCLES(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze(freeze), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we(sram_we), .sram_oe(sram_oe), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: 512 words indexed by byte address bits [10:2]; preloaded
  // while rst is high.
  logic [DW-1:0] sram_mem [0:511];

  always @(posedge clk) begin
    if (rst) begin
      sram_mem[9'h040] <= 32'hDEADBEEF;  // 0x100
      sram_mem[9'h080] <= 32'hA5A5A5A5;  // 0x200
      sram_mem[9'h0C0] <= 32'h0F0F0F0F;  // 0x300
      sram_mem[9'h100] <= 32'h00000000;  // 0x400
    end else if (sram_we) begin
      sram_mem[sram_addr[10:2]] <= sram_wdata;
    end
  end

  assign sram_rdata = sram_oe ? sram_mem[sram_addr[10:2]] : '0;

  // Advance to the next cycle and let driven inputs/outputs settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // ---------------- reset state ----------------
    cyc();
    cyc();
    chk32("rst_state", {30'b0, dut.state}, 32'd0);
    chk32("rst_sram_addr", sram_addr, 32'h0);
    chk1("rst_we", sram_we, 1'b0);
    chk1("rst_oe", sram_oe, 1'b0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_mem_ready", mem_ready, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    cyc();

    // ---------------- IF-only read of 0x100 ----------------
    if_req  = 1'b1;
    if_addr = 32'h100;
    #1;
    chk1("if_rd_c0_freeze", freeze, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk1("if_rd_oe", sram_oe, 1'b1);
      chk1("if_rd_we", sram_we, 1'b0);
      chk32("if_rd_addr", sram_addr, 32'h100);
      chk1("if_rd_ready_early", if_ready, 1'b0);
      chk1("if_rd_freeze", freeze, 1'b0);
    end
    cyc();  // cycle 5: RESP
    chk1("if_rd_ready", if_ready, 1'b1);
    chk32("if_rd_data", if_rdata, 32'hDEADBEEF);
    chk1("if_rd_c5_freeze", freeze, 1'b0);
    chk1("if_rd_c5_oe", sram_oe, 1'b0);
    chk32("if_rd_c5_addr", sram_addr, 32'h0);
    if_req = 1'b0;
    cyc();  // cycle 6: IDLE
    chk1("if_rd_ready_pulse", if_ready, 1'b0);
    chk32("if_rd_idle", {30'b0, dut.state}, 32'd0);

    // ---------------- MEM write of 0x12345678 to 0x400 ----------------
    mem_w_en  = 1'b1;
    mem_addr  = 32'h400;
    mem_wdata = 32'h12345678;
    #1;
    chk1("mem_wr_c0_freeze", freeze, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk1("mem_wr_we", sram_we, 1'b1);
      chk1("mem_wr_oe", sram_oe, 1'b0);
      chk32("mem_wr_addr", sram_addr, 32'h400);
      chk32("mem_wr_wdata", sram_wdata, 32'h12345678);
      chk1("mem_wr_freeze", freeze, 1'b1);
      chk1("mem_wr_ready_early", mem_ready, 1'b0);
    end
    cyc();  // cycle 5
    chk1("mem_wr_ready", mem_ready, 1'b1);
    chk1("mem_wr_c5_freeze", freeze, 1'b0);
    chk1("mem_wr_c5_we", sram_we, 1'b0);
    chk32("mem_wr_rdata_kept", mem_rdata, 32'h0);
    mem_w_en = 1'b0;
    cyc();
    chk1("mem_wr_ready_pulse", mem_ready, 1'b0);
    chk32("mem_wr_stored", sram_mem[9'h100], 32'h12345678);

    // ---------------- simultaneous IF and MEM read ----------------
    if_req   = 1'b1;
    if_addr  = 32'h300;
    mem_r_en = 1'b1;
    mem_addr = 32'h200;
    #1;
    chk1("both_c0_freeze", freeze, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk32("both_mem_addr", sram_addr, 32'h200);
      chk1("both_mem_oe", sram_oe, 1'b1);
      chk1("both_freeze", freeze, 1'b1);
    end
    cyc();  // cycle 5
    chk1("both_mem_ready", mem_ready, 1'b1);
    chk32("both_mem_rdata", mem_rdata, 32'hA5A5A5A5);
    chk1("both_c5_if_ready", if_ready, 1'b0);
    chk1("both_c5_freeze", freeze, 1'b0);
    mem_r_en = 1'b0;
    cyc();  // cycle 6: IDLE, IF granted on this cycle's edge
    chk32("both_c6_idle", {30'b0, dut.state}, 32'd0);
    chk1("both_c6_oe", sram_oe, 1'b0);
    for (int i = 7; i <= 10; i++) begin
      cyc();
      chk32("both_if_addr", sram_addr, 32'h300);
      chk1("both_if_ready_early", if_ready, 1'b0);
    end
    cyc();  // cycle 11
    chk1("both_if_ready", if_ready, 1'b1);
    chk32("both_if_rdata", if_rdata, 32'h0F0F0F0F);
    chk32("both_mem_rdata_kept", mem_rdata, 32'hA5A5A5A5);
    if_req = 1'b0;
    cyc();

    // ---------------- IF held while MEM requests in every IDLE cycle ----------------
    if_req  = 1'b1;
    if_addr = 32'h100;
    for (int r = 0; r < 3; r++) begin
      mem_r_en = 1'b1;
      mem_addr = 32'h200;
      #1;
      chk1("starve_c0_freeze", freeze, 1'b1);
      for (int i = 1; i <= 4; i++) begin
        cyc();
        chk32("starve_addr", sram_addr, 32'h200);
        chk1("starve_freeze", freeze, 1'b1);
        chk1("starve_if_ready", if_ready, 1'b0);
      end
      cyc();  // RESP
      chk1("starve_mem_ready", mem_ready, 1'b1);
      chk1("starve_resp_freeze", freeze, 1'b0);
      mem_r_en = 1'b0;
      cyc();  // IDLE
    end
    // MEM silent now: IF granted in this IDLE cycle, ready 5 cycles later.
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk32("starve_if_addr", sram_addr, 32'h100);
    end
    cyc();
    chk1("starve_if_done", if_ready, 1'b1);
    chk32("starve_if_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    cyc();

    // ---------------- reset in cycle 2 of a MEM read ----------------
    mem_r_en = 1'b1;
    mem_addr = 32'h300;
    cyc();  // cycle 1
    cyc();  // cycle 2
    chk1("rstmid_c2_oe", sram_oe, 1'b1);
    rst = 1'b1;
    cyc();  // cycle 3: reset applied on the previous edge
    chk32("rstmid_state", {30'b0, dut.state}, 32'd0);
    chk32("rstmid_addr", sram_addr, 32'h0);
    chk1("rstmid_oe", sram_oe, 1'b0);
    chk1("rstmid_we", sram_we, 1'b0);
    chk1("rstmid_mem_ready", mem_ready, 1'b0);
    chk32("rstmid_mem_rdata", mem_rdata, 32'h0);
    chk32("rstmid_if_rdata", if_rdata, 32'h0);
    rst = 1'b0;
    #1;
    chk1("rstmid_req_freeze", freeze, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk1("rstmid_no_ready", mem_ready, 1'b0);
      chk32("rstmid_re_addr", sram_addr, 32'h300);
    end
    cyc();
    chk1("rstmid_ready", mem_ready, 1'b1);
    chk32("rstmid_rdata", mem_rdata, 32'h0F0F0F0F);
    mem_r_en = 1'b0;
    cyc();

    // ---------------- read and write enables both high ----------------
    mem_r_en  = 1'b1;
    mem_w_en  = 1'b1;
    mem_addr  = 32'h200;
    mem_wdata = 32'hCAFEF00D;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk1("rw_we", sram_we, 1'b1);
      chk1("rw_oe", sram_oe, 1'b0);
    end
    cyc();
    chk1("rw_ready", mem_ready, 1'b1);
    chk32("rw_rdata_kept", mem_rdata, 32'h0F0F0F0F);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    cyc();
    chk32("rw_stored", sram_mem[9'h080], 32'hCAFEF00D);
    chk1("rw_ready_pulse", mem_ready, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
